prescaled_bcd_counter: RTL
==========================

PRESCALED_BCD_COUNTER -- requirements
Module: prescaled_bcd_counter

Interface
REQ-001 The block SHALL have parameter DIV, default 25000000, meaning prescaler modulus in clock cycles per count step (legal range 1..2^32-1).
REQ-002 The block SHALL have parameter DIGITS, default 4, meaning the number of cascaded BCD digits (legal range 1..8).
REQ-003 The block SHALL have port CLK, input, 1 bit, meaning the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RSTn, input, 1 bit, meaning reset; asynchronous, active-low.
REQ-005 The block SHALL have port ENABLE, input, 1 bit, meaning that 1 runs the prescaler and 0 freezes all state.
REQ-006 The block SHALL have port UP, input, 1 bit, meaning count direction: 1 counts up, 0 counts down.
REQ-007 The block SHALL have port CLR, input, 1 bit, meaning synchronous clear.
REQ-008 The block SHALL have port LOAD, input, 1 bit, meaning synchronous load strobe.
REQ-009 The block SHALL have port LOAD_VAL, input, 4*DIGITS bits, meaning BCD load value, digit 0 in bits [3:0].
REQ-010 The block SHALL have port COUNT, output, 4*DIGITS bits, meaning registered BCD count, digit 0 in bits [3:0].
REQ-011 The block SHALL have port TICK, output, 1 bit, meaning prescaler step pulse, combinational.
REQ-012 The block SHALL have port TC, output, 1 bit, meaning terminal-count carry/borrow out for cascading, combinational.

Function
REQ-013 The prescaler SHALL count 0..DIV-1 while ENABLE=1 and wrap to 0 after DIV-1.
REQ-014 TICK SHALL be 1 when ENABLE=1 and prescaler=DIV-1, giving a 1-cycle pulse every DIV cycles.
REQ-015 With DIV=1, TICK SHALL equal ENABLE.
REQ-016 On a TICK cycle with UP=1, digit 0 SHALL increment; a digit at 9 SHALL wrap to 0 and carry into the next digit in the same cycle.
REQ-017 On a TICK cycle with UP=0, digit 0 SHALL decrement; a digit at 0 SHALL wrap to 9 and borrow from the next digit in the same cycle.
REQ-018 Full-scale wrap SHALL be all-9 to all-0 when counting up and all-0 to all-9 when counting down.
REQ-019 TC SHALL be 1 when TICK=1 and all digits are 9 (UP=1) or all digits are 0 (UP=0); otherwise TC SHALL be 0.
REQ-020 UP SHALL be sampled only on TICK cycles; a change of UP between ticks SHALL have no effect on state.
REQ-021 ENABLE=0 SHALL hold both prescaler and COUNT, and SHALL force TICK=0 and TC=0.
REQ-022 Priority SHALL be CLR > LOAD > TICK, and both CLR and LOAD SHALL act regardless of ENABLE.
REQ-023 CLR=1 SHALL set the prescaler and COUNT to 0 on the next edge.
REQ-024 LOAD=1 (CLR=0) SHALL set COUNT to LOAD_VAL and the prescaler to 0 on the next edge, and SHALL suppress that cycle's step.
REQ-025 During load, any LOAD_VAL nibble greater than 9 SHALL be stored as 9.
REQ-026 COUNT SHALL never hold a nibble greater than 9.

Reset
REQ-027 RSTn=0 SHALL immediately, without a clock edge, force the prescaler to 0 and COUNT to 0, which forces TICK=0 and TC=0.
REQ-028 Reset asserted mid-count SHALL discard all state, and counting SHALL restart from prescaler 0 on the first edge after RSTn rises.

Configuration
REQ-029 Macro PRESCALED_BCD_COUNTER_LOAD_EN SHALL gate the load feature.
REQ-030 When PRESCALED_BCD_COUNTER_LOAD_EN is defined, LOAD and LOAD_VAL SHALL behave per REQ-022, REQ-024 and REQ-025.
REQ-031 When PRESCALED_BCD_COUNTER_LOAD_EN is undefined, the LOAD and LOAD_VAL ports SHALL remain present but be ignored, with no load logic synthesised.

Verification
REQ-032 The bench SHALL cover: DIV=4, DIGITS=2, UP=1, ENABLE=1 from reset -> TICK on cycles 4, 8, ...; COUNT=0x01 after the first tick, 0x10 after the tenth tick.
REQ-033 The bench SHALL cover: DIV=1, DIGITS=2, count up from 0x99 -> next COUNT=0x00, with TC=1 in the 0x99 cycle only.
REQ-034 The bench SHALL cover: DIV=1, DIGITS=3, UP=0 from 0x100 -> COUNT=0x099; from 0x000 -> COUNT=0x999 with TC=1.
REQ-035 The bench SHALL cover: LOAD=1, LOAD_VAL=0xA7 with CLR=1 in the same cycle -> COUNT=0x00; with CLR=0 -> COUNT=0x97 and prescaler=0.
REQ-036 The bench SHALL cover: ENABLE=0 for 10 cycles at prescaler=2, COUNT=0x05 -> all state held, TICK=0; on re-enable the next TICK occurs DIV-2 cycles later.
REQ-037 The bench SHALL cover: RSTn pulsed low mid-cycle at COUNT=0x42 -> COUNT=0x00 before the next CLK edge.

Source files
------------

// File: rtl/prescaled_bcd_counter.sv
// Prescaled multi-digit BCD up/down counter with cascade carry/borrow output.
// Optional synchronous load is compiled in when PRESCALED_BCD_COUNTER_LOAD_EN is defined.
module prescaled_bcd_counter #(
  parameter int unsigned DIV    = 25000000,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  ENABLE,
  input  logic                  UP,
  input  logic                  CLR,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   LOAD_VAL,
  output logic [4*DIGITS-1:0]   COUNT,
  output logic                  TICK,
  output logic                  TC
);

  localparam int unsigned   PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  logic [PW-1:0]          r_presc;
  logic [4*DIGITS-1:0]    r_count;
  logic [4*DIGITS-1:0]    w_count_next;
  logic                   w_tick;
  logic [DIGITS:0]        w_step;

  // RSTn gates the tick so a DIV=1 counter stays quiet while held in reset.
  assign w_tick    = ENABLE & RSTn & (r_presc == PRESC_MAX);
  assign w_step[0] = w_tick;

`ifdef PRESCALED_BCD_COUNTER_LOAD_EN
  logic [4*DIGITS-1:0]    w_load_bcd;
`else
  logic                   w_load_unused;
  assign w_load_unused = ^{LOAD, LOAD_VAL};
`endif

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] w_digit;
      assign w_digit = r_count[4*gi +: 4];

      // w_step[gi] is the ripple carry (up) or borrow (down) entering this digit.
      assign w_step[gi+1] = w_step[gi] & (UP ? (w_digit == 4'd9) : (w_digit == 4'd0));

      assign w_count_next[4*gi +: 4] =
        !w_step[gi] ? w_digit :
        UP          ? ((w_digit == 4'd9) ? 4'd0 : w_digit + 4'd1) :
                      ((w_digit == 4'd0) ? 4'd9 : w_digit - 4'd1);

`ifdef PRESCALED_BCD_COUNTER_LOAD_EN
      assign w_load_bcd[4*gi +: 4] =
        (LOAD_VAL[4*gi +: 4] > 4'd9) ? 4'd9 : LOAD_VAL[4*gi +: 4];
`endif
    end
  endgenerate

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_presc <= '0;
      r_count <= '0;
    end else if (CLR) begin
      r_presc <= '0;
      r_count <= '0;
`ifdef PRESCALED_BCD_COUNTER_LOAD_EN
    end else if (LOAD) begin
      r_presc <= '0;
      r_count <= w_load_bcd;
`endif
    end else if (ENABLE) begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      r_count <= w_count_next;
    end
  end

  assign COUNT = r_count;
  assign TICK  = w_tick;
  assign TC    = w_step[DIGITS];

endmodule
